// File: rtl/stream_route_2_pkg.sv
// Shared definitions for the stream_route_2 router stage:
// - input-side FSM state encoding (ST_IDLE, ST_IN_PKT)
// - route constants (ROUTE_0, ROUTE_1)
package stream_route_2_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } state_t;

   localparam logic ROUTE_0 = 1'b0;
   localparam logic ROUTE_1 = 1'b1;

endpackage

// File: rtl/stream_reg_1.sv
// One-entry valid/ready register slice.
// The payload is opaque here. The downstream ready is chosen by the
// parent module, so this slice only sees a single out_ready.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   in_valid         upstream beat valid
//   in_ready         upstream beat accepted when in_valid & in_ready
//   in_payload       upstream payload
//   out_valid        registered beat valid
//   out_ready        downstream ready (already selected by the parent)
//   out_payload      registered payload
module stream_reg_1 #(
   parameter int PAYLOAD_WIDTH = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_WIDTH-1:0] in_payload,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_WIDTH-1:0] out_payload
);

   logic in_fire;
   logic out_fire;

   // The slot may refill in the same cycle it drains, so there is no bubble.
   assign in_ready = ~rst_i & (~out_valid | out_ready);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid   <= 1'b0;
         out_payload <= '0;
      end else if (in_fire) begin
         out_valid   <= 1'b1;
         out_payload <= in_payload;
      end else if (out_fire) begin
         // Payload holds its value after it drains.
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_route_2.sv
// Registered, packet-aware 1-to-2 stream router stage that feeds demux_2.
// The destination is locked on the first beat of each packet. Only the
// selected sink's ready stalls the stream. Completed packets are counted
// per sink, and each counter saturates.
//
// Optional feature: define STREAM_ROUTE_2_RR_EN to route packets round-robin
// and ignore s_dest_i. The pointer toggles when the last beat of each packet
// is accepted, and the first packet after reset goes to sink 0.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   s_valid_i/s_ready_o          input handshake
//   s_data_i, s_dest_i, s_last_i input payload, destination, end of packet
//   select_o, data_o             registered route and payload to demux_2
//   valid_o, last_o              registered beat qualifiers
//   ready_0_i, ready_1_i         sink readies
//   busy_o                       input side is mid-packet
//   pkt_cnt_0_o, pkt_cnt_1_o     completed-packet counters
//
// Input FSM
//   state     | meaning
//   ST_IDLE   | next accepted beat is a packet's first beat; route is taken fresh
//   ST_IN_PKT | mid-packet; beats reuse the locked route_q
module stream_route_2
   import stream_route_2_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int PKT_CNT_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   input  logic [DATA_WIDTH-1:0]    s_data_i,
   input  logic                     s_dest_i,
   input  logic                     s_last_i,
   output logic                     select_o,
   output logic [DATA_WIDTH-1:0]    data_o,
   output logic                     valid_o,
   output logic                     last_o,
   input  logic                     ready_0_i,
   input  logic                     ready_1_i,
   output logic                     busy_o,
   output logic [PKT_CNT_WIDTH-1:0] pkt_cnt_0_o,
   output logic [PKT_CNT_WIDTH-1:0] pkt_cnt_1_o
);

   localparam int PAYLOAD_WIDTH = DATA_WIDTH + 2;

   state_t state_q, state_d;
   logic   route_q, route_d;
   logic   first_route;
   logic   beat_route;
   logic   out_ready;
   logic   in_fire;
   logic   out_fire;

   logic [PAYLOAD_WIDTH-1:0] in_payload;
   logic [PAYLOAD_WIDTH-1:0] out_payload;

   // The held beat carries its own route, so the readies are muxed on it.
   assign out_ready = (select_o == ROUTE_1) ? ready_1_i : ready_0_i;
   assign in_fire   = s_valid_i & s_ready_o;
   assign out_fire  = valid_o & out_ready;

`ifdef STREAM_ROUTE_2_RR_EN
   logic rr_ptr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= ROUTE_0;
      end else if (in_fire && s_last_i) begin
         rr_ptr_q <= ~rr_ptr_q;
      end
   end

   assign first_route = rr_ptr_q;
`else
   assign first_route = s_dest_i;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         route_q <= ROUTE_0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      route_d    = route_q;
      beat_route = first_route;
      case (state_q)
         ST_IDLE: begin
            if (in_fire) begin
               route_d = first_route;
               if (!s_last_i) begin
                  state_d = ST_IN_PKT;
               end
            end
         end
         ST_IN_PKT: begin
            beat_route = route_q;
            if (in_fire && s_last_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_o     = (state_q == ST_IN_PKT);
   assign in_payload = {s_data_i, beat_route, s_last_i};

   stream_reg_1 #(
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
   ) u_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid    (s_valid_i),
      .in_ready    (s_ready_o),
      .in_payload  (in_payload),
      .out_valid   (valid_o),
      .out_ready   (out_ready),
      .out_payload (out_payload)
   );

   assign data_o   = out_payload[PAYLOAD_WIDTH-1:2];
   assign select_o = out_payload[1];
   assign last_o   = out_payload[0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pkt_cnt_0_o <= '0;
         pkt_cnt_1_o <= '0;
      end else if (out_fire && last_o) begin
         if (select_o == ROUTE_0) begin
            if (pkt_cnt_0_o != '1) begin
               pkt_cnt_0_o <= pkt_cnt_0_o + 1'b1;
            end
         end else begin
            if (pkt_cnt_1_o != '1) begin
               pkt_cnt_1_o <= pkt_cnt_1_o + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_route_2.sv
module tb_stream_route_2;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        rst_i = 1'b0;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o;
   logic [7:0]  s_data_i = '0;
   logic        s_dest_i = 1'b0;
   logic        s_last_i = 1'b0;
   logic        select_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        last_o;
   logic        ready_0_i = 1'b0;
   logic        ready_1_i = 1'b0;
   logic        busy_o;
   logic [15:0] pkt_cnt_0_o;
   logic [15:0] pkt_cnt_1_o;

   logic        sat_s_ready;
   logic        sat_select;
   logic [7:0]  sat_data;
   logic        sat_valid;
   logic        sat_last;
   logic        sat_busy;
   logic [1:0]  sat_cnt_0;
   logic [1:0]  sat_cnt_1;

   stream_route_2 #(.DATA_WIDTH(8), .PKT_CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
      .s_dest_i(s_dest_i), .s_last_i(s_last_i),
      .select_o(select_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
      .ready_0_i(ready_0_i), .ready_1_i(ready_1_i), .busy_o(busy_o),
      .pkt_cnt_0_o(pkt_cnt_0_o), .pkt_cnt_1_o(pkt_cnt_1_o)
   );

   stream_route_2 #(.DATA_WIDTH(8), .PKT_CNT_WIDTH(2)) dut_sat (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_valid_i(s_valid_i), .s_ready_o(sat_s_ready), .s_data_i(s_data_i),
      .s_dest_i(s_dest_i), .s_last_i(s_last_i),
      .select_o(sat_select), .data_o(sat_data), .valid_o(sat_valid), .last_o(sat_last),
      .ready_0_i(ready_0_i), .ready_1_i(ready_1_i), .busy_o(sat_busy),
      .pkt_cnt_0_o(sat_cnt_0), .pkt_cnt_1_o(sat_cnt_1)
   );

   typedef struct {
      logic [7:0] data;
      logic       route;
      logic       last;
   } beat_t;

   // Reference model: the beats the router owes its sinks, in order,
   // plus packet bookkeeping.
   beat_t exp_q[$];
   bit    pkt_active;
   bit    pkt_route;
   bit    rr_ptr;
   int    cnt0, cnt1;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef STREAM_ROUTE_2_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      pkt_active = 0;
      pkt_route  = 0;
      rr_ptr     = 0;
      cnt0       = 0;
      cnt1       = 0;
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit dest, input bit last,
                        input bit r0, input bit r1);
      s_valid_i = v;
      s_data_i  = d;
      s_dest_i  = dest;
      s_last_i  = last;
      ready_0_i = r0;
      ready_1_i = r1;
   endtask

   // One clock: compare DUT against the model at the negedge, then advance
   // the model at the posedge. Returns 1 ns after the posedge.
   task automatic step();
      bit    hv, ordy, exp_sr, ofire, ifire, rt;
      beat_t h, nb;
      @(negedge clk_i);
      hv = (exp_q.size() > 0);
      h  = '{data: 8'h00, route: 1'b0, last: 1'b0};
      if (hv) h = exp_q[0];
      ordy   = hv && (h.route ? ready_1_i : ready_0_i);
      exp_sr = !rst_i && (!hv || ordy);
      check("s_ready", {31'd0, s_ready_o}, {31'd0, exp_sr});
      check("valid",   {31'd0, valid_o},   {31'd0, hv});
      check("busy",    {31'd0, busy_o},    {31'd0, pkt_active});
      check("sat_valid", {31'd0, sat_valid}, {31'd0, hv});
      check("sat_busy",  {31'd0, sat_busy},  {31'd0, pkt_active});
      check("sat_s_ready", {31'd0, sat_s_ready}, {31'd0, exp_sr});
      if (hv) begin
         check("data",   {24'd0, data_o},    {24'd0, h.data});
         check("select", {31'd0, select_o},  {31'd0, h.route});
         check("last",   {31'd0, last_o},    {31'd0, h.last});
         check("sat_data",   {24'd0, sat_data},   {24'd0, h.data});
         check("sat_select", {31'd0, sat_select}, {31'd0, h.route});
         check("sat_last",   {31'd0, sat_last},   {31'd0, h.last});
      end
      check("cnt0", {16'd0, pkt_cnt_0_o}, sat(cnt0, 65535));
      check("cnt1", {16'd0, pkt_cnt_1_o}, sat(cnt1, 65535));
      check("sat_cnt0", {30'd0, sat_cnt_0}, sat(cnt0, 3));
      check("sat_cnt1", {30'd0, sat_cnt_1}, sat(cnt1, 3));
      ofire = hv && ordy;
      ifire = s_valid_i && exp_sr;
      @(posedge clk_i);
      if (ofire) begin
         if (h.last) begin
            if (h.route) cnt1++; else cnt0++;
         end
         void'(exp_q.pop_front());
      end
      if (ifire) begin
         rt = pkt_active ? pkt_route : (RR ? rr_ptr : s_dest_i);
         nb = '{data: s_data_i, route: rt, last: s_last_i};
         exp_q.push_back(nb);
         pkt_active = !s_last_i;
         pkt_route  = rt;
         if (s_last_i) rr_ptr = !rr_ptr;
      end
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst_i = 1'b1;
      #1;
      model_clear();
      check("rst_valid",   {31'd0, valid_o},   32'd0);
      check("rst_s_ready", {31'd0, s_ready_o}, 32'd0);
      check("rst_busy",    {31'd0, busy_o},    32'd0);
      check("rst_cnt0",    {16'd0, pkt_cnt_0_o}, 32'd0);
      check("rst_cnt1",    {16'd0, pkt_cnt_1_o}, 32'd0);
      repeat (cycles) step();
      rst_i = 1'b0;
   endtask

   initial begin
      model_clear();
      drive(0, 8'h00, 0, 0, 1, 1);
      #1;
      do_reset(2);
      check("rst_select", {31'd0, select_o}, 32'd0);
      check("rst_data",   {24'd0, data_o},   32'd0);
      step();

      // Packet lock: destination from the first beat only.
      drive(1, 8'hA1, 1, 0, 1, 1); step();
      drive(1, 8'hA2, 0, 0, 1, 1); step();
      drive(1, 8'hA3, 0, 1, 1, 1); step();
      drive(0, 8'h00, 0, 0, 1, 1); step(); step();
      check("lock_cnt1", {16'd0, pkt_cnt_1_o}, RR ? 32'd0 : 32'd1);
      check("lock_cnt0", {16'd0, pkt_cnt_0_o}, RR ? 32'd1 : 32'd0);

      // Backpressure on sink 1 while sink 0 is ready.
      do_reset(1);
      drive(1, 8'h5C, 1, 1, 1, 0); step();
      drive(0, 8'h00, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("bp_data", {24'd0, data_o}, RR ? data_o : 32'h5C);
         check("bp_s_ready", {31'd0, s_ready_o}, RR ? {31'd0, s_ready_o} : 32'd0);
      end
      drive(0, 8'h00, 0, 0, 1, 1); step(); step();
      check("bp_drained", {31'd0, valid_o}, 32'd0);

      // Back-to-back single-beat packets.
      do_reset(1);
      drive(1, 8'h10, 0, 1, 1, 1); step();
      drive(1, 8'h11, 1, 1, 1, 1); step();
      drive(1, 8'h12, 0, 1, 1, 1); step();
      drive(0, 8'h00, 0, 0, 1, 1); step(); step();
      check("b2b_cnt0", {16'd0, pkt_cnt_0_o}, 32'd2);
      check("b2b_cnt1", {16'd0, pkt_cnt_1_o}, 32'd1);

      // Reset in the middle of a 4-beat packet.
      do_reset(1);
      drive(1, 8'h21, 1, 0, 1, 1); step();
      drive(1, 8'h22, 1, 0, 1, 1); step();
      check("mid_valid_before", {31'd0, valid_o}, 32'd1);
      do_reset(2);
      drive(1, 8'h30, 0, 1, 1, 1); step();
      drive(0, 8'h00, 0, 0, 1, 1); step();
      check("mid_select_after", {31'd0, select_o}, 32'd0);
      step();

      // Saturation of the 2-bit counters.
      do_reset(1);
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'h40 + 8'(i), 0, 1, 1, 1); step();
      end
      drive(0, 8'h00, 0, 0, 1, 1); step(); step();
      check("sat_held",  {30'd0, sat_cnt_0}, 32'd3);
      check("sat_wide",  {16'd0, pkt_cnt_0_o}, RR ? 32'd3 : 32'd5);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(1 + $urandom_range(0, 2));
         end else begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step();
         end
      end
      drive(0, 8'h00, 0, 0, 1, 1);
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_route_2.md
# stream_route_2

Registered, packet-aware 1-to-2 stream router stage that sits directly upstream of `demux_2`. It accepts a valid/ready input stream carrying a per-packet destination bit. It produces `select_o`/`data_o` for `demux_2`, plus a valid/last qualifier and per-output packet counters. The destination is locked for a whole packet, and only the selected sink's ready applies backpressure.

## Interface
- `DATA_WIDTH`, 8: payload width; matches `demux_2` `DATA_WIDTH`.
- `PKT_CNT_WIDTH`, 16: width of each saturating completed-packet counter.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `s_valid_i`  in  1  input beat valid.
- `s_ready_o`  out  1  input beat accepted when `s_valid_i & s_ready_o`.
- `s_data_i`  in  DATA_WIDTH  input payload.
- `s_dest_i`  in  1  destination (0/1); sampled on first beat of a packet only.
- `s_last_i`  in  1  final beat of packet.
- `select_o`  out  1  route of registered beat; drives `demux_2` `select_i`.
- `data_o`  out  DATA_WIDTH  registered payload; drives `demux_2` `data_i`.
- `valid_o`  out  1  registered beat valid.
- `last_o`  out  1  registered beat is last of packet.
- `ready_0_i`  in  1  sink 0 ready.
- `ready_1_i`  in  1  sink 1 ready.
- `busy_o`  out  1  high while in ST_IN_PKT (mid-packet on input side).
- `pkt_cnt_0_o`  out  PKT_CNT_WIDTH  packets completed to sink 0.
- `pkt_cnt_1_o`  out  PKT_CNT_WIDTH  packets completed to sink 1.

## Operation
- Output register: one entry holding {`valid_o`, `data_o`, `select_o`, `last_o`}.
- `out_ready = select_o ? ready_1_i : ready_0_i`. The unselected sink's ready is ignored.
- `out_fire = valid_o & out_ready`.
- `s_ready_o = ~rst_i & (~valid_o | out_ready)`, combinational.
- On `in_fire` the register loads the beat, with `select_o` = the beat's route and `valid_o`=1.
- On `out_fire` without `in_fire`, `valid_o`→0. `data_o`, `select_o` and `last_o` hold their values.
- Input FSM:
  - ST_IDLE: on `in_fire`, route = `s_dest_i`; `route_q` ← route. Go to ST_IN_PKT unless `s_last_i`.
  - ST_IN_PKT: every accepted beat uses `route_q` and `s_dest_i` is ignored. An accepted beat with `s_last_i` returns to ST_IDLE.
- Per-beat route is stored in the register, so a new packet may be accepted while the previous packet's last beat is still draining. There are no bubbles.
- Counters: on `out_fire & last_o`, increment `pkt_cnt_<select_o>_o`, saturating at all-ones.
- Reset values: `valid_o`=0, `data_o`=0, `select_o`=0, `last_o`=0, `busy_o`=0, counters=0, FSM=ST_IDLE, RR pointer=0. `s_ready_o`=0 while `rst_i` is high.

## Timing
- Latency: 1 cycle from `in_fire` to `valid_o`.
- Throughput: 1 beat/cycle while the selected sink is ready.
- Combinational path `ready_x_i` → `s_ready_o` (pass-through).
- Single-beat packet (`s_last_i` on first beat): FSM stays in ST_IDLE; a fresh route is taken every beat.
- Simultaneous `out_fire` and `in_fire`: the register loads the new beat and `valid_o` stays 1.
- Backpressure: while `valid_o & ~out_ready`, all output fields hold stable.
- Reset mid-packet: the held beat is dropped and the FSM goes to ST_IDLE. The next accepted beat is treated as a first beat. Counters clear.
- Counter saturation: at all-ones, the counter holds; there is no wrap.

## Configuration
- `STREAM_ROUTE_2_RR_EN` defined:
  - Route on a first beat = RR pointer, and `s_dest_i` is ignored.
  - The pointer toggles on input acceptance of each packet's last beat. The first packet after reset goes to 0.
- Undefined: route = `s_dest_i`; no RR pointer logic is present.

## Structure
- Package `stream_route_2_pkg`: FSM state localparams ST_IDLE/ST_IN_PKT, and ROUTE_0/ROUTE_1 constants.
- One natural sub-module: `stream_reg_1`, a one-entry valid/ready register slice. Its payload is {data, route, last}, with ready selected outside it. The FSM, route logic and counters stay in the top module.

## Test plan
- **Reset:** hold `rst_i`=1 → `s_ready_o`=0, `valid_o`=0, `select_o`=0, counters 0. After release with `valid_o`=0 → `s_ready_o`=1.
- **Packet lock:** 3-beat packet 0xA1, 0xA2, 0xA3 with `s_dest_i`=1,0,0, both sinks ready → three beats with `select_o`=1 one cycle after each accept, `last_o` on 0xA3, `pkt_cnt_1_o`=1, `pkt_cnt_0_o`=0.
- **Backpressure:** beat to sink 1, `ready_1_i`=0 for 4 cycles, `ready_0_i`=1 → `data_o`/`select_o` stable, `s_ready_o`=0 for 4 cycles, then drains in 1 cycle.
- **Back-to-back single-beat packets:** `s_dest_i`=0,1,0, both ready → one beat/cycle, `select_o`=0,1,0, `pkt_cnt_0_o`=2, `pkt_cnt_1_o`=1.
  - RR build with `s_dest_i`=1,1,1 → `select_o`=0,1,0.
- **Reset mid-packet:** assert `rst_i` after beat 2 of 4 (dest=1) → `valid_o`=0 immediately. After release, a beat with `s_dest_i`=0 is routed to `select_o`=0.
- **Saturation:** `PKT_CNT_WIDTH`=2, five 1-beat packets to sink 0 → `pkt_cnt_0_o`=3, held.
